// File: rtl/data_matrix_mem_if_pkg.sv
// ---------------------------------------------------------------------------
// data_matrix_mem_if_pkg
// Shared definitions for the LC-3 MAR/MDR memory interface stage:
//   - state_e           : handshake FSM state encoding (IDLE / REQ / DONE)
//   - MEM_RD / MEM_WR   : r_w encodings as driven by the control unit
//   - TIMEOUT_DEFAULT   : default watchdog limit (cycles of unacked mem_req)
//   - CNT_W_DEFAULT     : default watchdog counter width
// ---------------------------------------------------------------------------
package data_matrix_mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/data_matrix_mem_wdog.sv
// ---------------------------------------------------------------------------
// data_matrix_mem_wdog
// Wait-cycle counter for the memory handshake. Counts cycles in which a
// request is outstanding and flags the last permitted cycle.
// Ports:
//   clk, rst_n : clock / asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : increment by one this cycle
//   expired    : counter currently equals TIMEOUT-1 (final wait cycle)
// ---------------------------------------------------------------------------
module data_matrix_mem_wdog
    import data_matrix_mem_if_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/data_matrix_mem_if.sv
// ---------------------------------------------------------------------------
// data_matrix_mem_if
// LC-3 memory interface stage: MAR/MDR registers plus a req/ack handshake
// engine that turns the control unit's level mio_en/r_w into one memory
// transaction and returns a one-cycle ready pulse r.
// Ports:
//   clk, rst_n          : clock / asynchronous active-low reset
//   bus                 : datapath bus (MAR/MDR load source)
//   ld_mar, ld_mdr      : register load strobes
//   mio_en, r_w         : access request (level) and direction (1 = write)
//   err_clr             : clears the sticky timeout flag
//   mar, mdr            : architectural registers (mdr feeds gate_mdr)
//   r                   : ready pulse at access completion
//   err                 : sticky watchdog timeout flag
//   mem_req/we/addr/wdata, mem_rdata, mem_ack : memory-side handshake
// ---------------------------------------------------------------------------
module data_matrix_mem_if
    import data_matrix_mem_if_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        err_clr,
    output logic [15:0] mar,
    output logic [15:0] mdr,
    output logic        r,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state_q,     state_d;
    logic [15:0] mar_q,       mar_d;
    logic [15:0] mdr_q,       mdr_d;
    logic [15:0] rbuf_q,      rbuf_d;
    logic        r_q,         r_d;
    logic        err_q,       err_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;

    logic wd_clr;
    logic wd_en;
    logic wd_expired;
    logic err_set;

    // Counter sits at zero whenever idle, so every access starts fresh;
    // it only advances on REQ cycles that were not acknowledged.
    assign wd_clr = (state_q == ST_IDLE);
    assign wd_en  = (state_q == ST_REQ) && !mem_ack;

    data_matrix_mem_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        rbuf_d      = rbuf_q;
        r_d         = 1'b0;
        err_set     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (mio_en) begin
                    // Snapshot the access; later MAR/MDR loads do not disturb it.
                    state_d     = ST_REQ;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = mar_q;
                    mem_wdata_d = mdr_q;
                    mem_we_d    = r_w;
                end
            end
            ST_REQ: begin
                // Ack is checked first so an ack on the expiry cycle still wins.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q == MEM_RD) begin
                        rbuf_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                    r_d     = 1'b1;
                end else if (wd_expired) begin
                    mem_req_d = 1'b0;
                    err_set   = 1'b1;
                    rbuf_d    = 16'h0000;
                    state_d   = ST_DONE;
                    r_d       = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Timeout set dominates a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        mar_d = ld_mar ? bus : mar_q;

        // With mio_en high, MDR only takes memory data in the ready cycle.
        mdr_d = mdr_q;
        if (ld_mdr) begin
            if (!mio_en) begin
                mdr_d = bus;
            end else if (r_q) begin
                mdr_d = rbuf_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mar_q       <= 16'h0000;
            mdr_q       <= 16'h0000;
            rbuf_q      <= 16'h0000;
            r_q         <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            rbuf_q      <= rbuf_d;
            r_q         <= r_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mar       = mar_q;
    assign mdr       = mdr_q;
    assign r         = r_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_matrix_mem_if.sv
// ---------------------------------------------------------------------------
// tb_data_matrix_mem_if
// Directed scenarios followed by randomized accesses against a behavioural
// model: a sparse memory, expected MAR/MDR/err values and the rule that an
// access lasts min(wait+1, TIMEOUT) request cycles.
// ---------------------------------------------------------------------------
module tb_data_matrix_mem_if;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio_en, r_w, err_clr;
    logic [15:0] mar, mdr;
    logic        r, err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [15:0] mar_m, mdr_m;
    logic        err_m;
    logic [15:0] mem_m [logic [15:0]];

    data_matrix_mem_if #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .err_clr   (err_clr),
        .mar       (mar),
        .mdr       (mdr),
        .r         (r),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access. wait_cyc = unacked REQ cycles before the ack;
    // wait_cyc >= TIMEOUT means memory never answers.
    task automatic do_access(input logic [15:0] addr, input logic [15:0] wdata,
                             input logic is_wr, input int wait_cyc,
                             input logic [15:0] rdata, input logic disturb);
        int n;
        int exp_cycles;
        logic timed_out;
        logic [15:0] start_mdr;
        timed_out  = (wait_cyc >= TIMEOUT);
        exp_cycles = timed_out ? TIMEOUT : wait_cyc + 1;

        bus = addr; ld_mar = 1'b1; step(); ld_mar = 1'b0; mar_m = addr;
        if (is_wr) begin
            bus = wdata; ld_mdr = 1'b1; mio_en = 1'b0; step(); ld_mdr = 1'b0; mdr_m = wdata;
        end
        check("mar_before", mar, mar_m);
        check("mdr_before", mdr, mdr_m);
        start_mdr = mdr_m;

        mio_en = 1'b1; r_w = is_wr; ld_mdr = !is_wr; bus = $urandom;
        step();
        check("req_rise", {15'b0, mem_req}, 16'h0001);
        n = 0;
        while (mem_req === 1'b1 && n < TIMEOUT + 4) begin
            check("mem_addr", mem_addr, addr);
            check("mem_we", {15'b0, mem_we}, {15'b0, is_wr});
            check("mem_wdata", mem_wdata, start_mdr);
            check("r_during_req", {15'b0, r}, 16'h0000);
            check("mdr_during_req", mdr, start_mdr);
            if (n == wait_cyc) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
            if (disturb && n == 0) begin
                ld_mar = 1'b1; bus = 16'hFFFF; mar_m = 16'hFFFF;
            end else begin
                ld_mar = 1'b0; bus = $urandom;
            end
            step();
            n++;
        end
        mem_ack = 1'b0; ld_mar = 1'b0;
        check("req_cycles", 16'(n), 16'(exp_cycles));
        check("r_pulse", {15'b0, r}, 16'h0001);
        if (timed_out) err_m = 1'b1;
        else if (is_wr) mem_m[addr] = start_mdr;
        check("err_at_done", {15'b0, err}, {15'b0, err_m});
        step();
        if (!is_wr) mdr_m = timed_out ? 16'h0000 : rdata;
        check("r_single", {15'b0, r}, 16'h0000);
        check("mdr_after", mdr, mdr_m);
        check("mar_after", mar, mar_m);
        mio_en = 1'b0; ld_mdr = 1'b0;
    endtask

    initial begin
        logic [15:0] a, d, rd;
        logic wr;
        int w;

        rst_n = 1'b0; bus = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        err_clr = 0; mem_rdata = '0; mem_ack = 0;
        mar_m = '0; mdr_m = '0; err_m = 1'b0;
        #12;
        check("rst_mar", mar, 16'h0000);
        check("rst_mdr", mdr, 16'h0000);
        check("rst_r", {15'b0, r}, 16'h0000);
        check("rst_err", {15'b0, err}, 16'h0000);
        check("rst_req", {15'b0, mem_req}, 16'h0000);
        check("rst_we", {15'b0, mem_we}, 16'h0000);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdata", mem_wdata, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        step();

        // Idle with random MAR traffic and stray acks: nothing should start.
        for (int i = 0; i < 8; i++) begin
            bus = $urandom; ld_mar = $urandom_range(0, 1); mem_ack = $urandom_range(0, 1);
            if (ld_mar) mar_m = bus;
            step();
            check("idle_req", {15'b0, mem_req}, 16'h0000);
            check("idle_r", {15'b0, r}, 16'h0000);
            check("idle_mar", mar, mar_m);
        end
        ld_mar = 0; mem_ack = 0;

        // Directed: zero-wait read, 3-wait write, timeout, ack-on-expiry, disturbance.
        do_access(16'h3000, 16'h0000, 1'b0, 0, 16'h1234, 1'b0);
        do_access(16'h4001, 16'hBEEF, 1'b1, 3, 16'h0000, 1'b0);
        do_access(16'h5000, 16'h0000, 1'b0, TIMEOUT + 3, 16'h7777, 1'b0);
        check("err_sticky", {15'b0, err}, 16'h0001);
        err_clr = 1'b1; step(); err_clr = 1'b0; err_m = 1'b0;
        check("err_cleared", {15'b0, err}, 16'h0000);
        do_access(16'h5001, 16'h0000, 1'b0, TIMEOUT - 1, 16'hA5C3, 1'b0);
        do_access(16'h6000, 16'h0000, 1'b0, 2, 16'h0F0F, 1'b1);
        check("disturb_mar", mar, 16'hFFFF);

        // err_clr held through a timeout: the set must win.
        err_clr = 1'b1;
        do_access(16'h6100, 16'h0000, 1'b0, TIMEOUT + 1, 16'h0000, 1'b0);
        err_clr = 1'b0;
        step(); err_m = 1'b0;
        check("err_clr_after", {15'b0, err}, 16'h0000);

        // Randomized traffic against the sparse memory model.
        for (int i = 0; i < 24; i++) begin
            a  = 16'($urandom_range(0, 7)) + 16'h8000;
            wr = $urandom_range(0, 1);
            d  = $urandom;
            w  = $urandom_range(0, TIMEOUT + 2);
            if (!mem_m.exists(a)) mem_m[a] = $urandom;
            rd = mem_m[a];
            do_access(a, d, wr, w, rd, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1; step(); err_clr = 1'b0; err_m = 1'b0;
                check("rand_err_clr", {15'b0, err}, 16'h0000);
            end
        end

        // Reset in the middle of a request.
        bus = 16'h2222; ld_mar = 1'b1; step(); ld_mar = 1'b0;
        mio_en = 1'b1; r_w = 1'b0; step();
        check("pre_reset_req", {15'b0, mem_req}, 16'h0001);
        step();
        rst_n = 1'b0; #1;
        check("async_req_drop", {15'b0, mem_req}, 16'h0000);
        check("async_mar", mar, 16'h0000);
        mio_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_no_r", {15'b0, r}, 16'h0000);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_r", {15'b0, r}, 16'h0000);
            check("post_reset_req", {15'b0, mem_req}, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
